// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: funct3 encodings and FSM states shared by the load/store unit.
package rv_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, RMW_WRITE} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: extracts and extends load lanes and merges store lanes into a word.
module lsu_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [31:0] lanes;
  always_comb begin
    sh = {offset, 3'b000};
    b = 8'(word >> sh);
    h = offset[1] ? word[31:16] : word[15:0];
    load_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'h0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'h0, h} : word;
    mask = funct3 == F3_B ? 32'hff << sh :
           funct3 == F3_H ? 32'hffff << {offset[1], 4'b0000} : 32'hffff_ffff;
    lanes = funct3 == F3_B ? {4{store_data[7:0]}} :
            funct3 == F3_H ? {2{store_data[15:0]}} : store_data;
    merged = (word & ~mask) | (lanes & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores onto word memory; sub-word stores use a two-cycle read-modify-write.
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        fault_now,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  input  logic        fault_clear,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  lsu_state_t  state, next_state;
  logic [31:0] rmw_addr, rmw_data, merged, aligned_load;
  logic        legal, misaligned, out_of_range, idle_req, go, sub_store, direct_store, rmw;

  lsu_lane_align u_align (
    .funct3     (req_funct3),
    .offset     (req_addr[1:0]),
    .word       (mem_rdata),
    .store_data (req_wdata),
    .load_data  (aligned_load),
    .merged     (merged)
  );

  always_comb begin
    legal = req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
            (!req_write && (req_funct3 == F3_BU || req_funct3 == F3_HU));
    misaligned = (req_funct3 == F3_W && req_addr[1:0] != 2'b00) ||
                 ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]);
    out_of_range = req_addr >= 32'(4 * MEM_WORDS);
    // Gating with rst_n keeps every output low while reset is held.
    idle_req = rst_n && state == IDLE && req_valid;
    fault_now = idle_req && (!legal || misaligned || out_of_range);
    go = idle_req && !fault_now;
    sub_store = req_write && (req_funct3 == F3_B || req_funct3 == F3_H);
    direct_store = go && req_write && !sub_store;
  end

  always_comb next_state = (state == IDLE && go && sub_store) ? RMW_WRITE : IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rmw_addr <= 32'h0;
      rmw_data <= 32'h0;
    end else begin
      state <= next_state;
      if (stall) begin
        rmw_addr <= {req_addr[31:2], 2'b00};
        rmw_data <= merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid <= 1'b0;
      fault_addr <= 32'h0;
    end else if (fault_clear) begin
      fault_valid <= 1'b0;
      fault_addr <= 32'h0;
    end else if (fault_now && !fault_valid) begin
      fault_valid <= 1'b1;
      fault_addr <= req_addr;
    end
  end

  always_comb begin
    rmw = rst_n && state == RMW_WRITE;
    stall = go && sub_store;
    mem_read = go && (!req_write || sub_store);
    mem_write = rmw || direct_store;
    mem_addr = rmw ? rmw_addr : go ? {req_addr[31:2], 2'b00} : 32'h0;
    mem_wdata = rmw ? rmw_data : direct_store ? req_wdata : 32'h0;
    load_data = (go && !req_write) ? aligned_load : 32'h0;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_load_store_unit;
  import rv_mem_pkg::*;
  logic        clk = 0, rst_n = 1, req_valid = 0, req_write = 0, fault_clear = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata;
  logic        stall, fault_now, fault_valid, mem_read, mem_write;
  logic [31:0] load_data, fault_addr, mem_addr, mem_wdata;
  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  int vectors = 0, miscompares = 0;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t pend_q[$];
  logic        efv = 0;
  logic [31:0] efa = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .fault_now(fault_now),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_clear(fault_clear),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_fault(bit wr, logic [2:0] f3, logic [31:0] a);
    logic [31:0] size;
    bit ok;
    ok = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = f3[1:0] == 2'd0 ? 32'd1 : f3[1:0] == 2'd1 ? 32'd2 : 32'd4;
    return !ok || (a % size != 0) || (a >= 32'd256);
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * a[1:0]);
    case (f3)
      3'd0: return 32'($signed(v[7:0]));
      3'd4: return {24'h0, v[7:0]};
      3'd1: return 32'($signed(v[15:0]));
      3'd5: return {16'h0, v[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(logic [2:0] f3, logic [31:0] a, logic [31:0] w, logic [31:0] d);
    logic [31:0] mask;
    mask = (f3 == 3'd0 ? 32'hff : 32'hffff) << (8 * a[1:0]);
    return (w & ~mask) | ((d << (8 * a[1:0])) & mask);
  endfunction

  always @(negedge clk) begin
    logic [31:0] e_ld, e_addr, e_wd;
    logic        e_rd, e_wr, e_st, e_fn;
    wr_t         p;
    e_ld = 0; e_addr = 0; e_wd = 0; e_rd = 0; e_wr = 0; e_st = 0; e_fn = 0;
    if (!rst_n) begin
      pend_q.delete();
      efv = 0;
      efa = 0;
    end else if (pend_q.size() != 0) begin
      p = pend_q.pop_front();
      e_wr = 1; e_addr = p.addr; e_wd = p.data;
      ref_mem[p.addr[7:2]] = p.data;
    end else if (req_valid) begin
      if (model_fault(req_write, req_funct3, req_addr)) e_fn = 1;
      else begin
        e_addr = req_addr & ~32'h3;
        if (!req_write) begin
          e_rd = 1;
          e_ld = model_load(req_funct3, req_addr, ref_mem[req_addr[7:2]]);
        end else if (req_funct3 == 3'd2) begin
          e_wr = 1; e_wd = req_wdata;
          ref_mem[req_addr[7:2]] = req_wdata;
        end else begin
          e_rd = 1; e_st = 1;
          p.addr = e_addr;
          p.data = model_merge(req_funct3, req_addr, ref_mem[req_addr[7:2]], req_wdata);
          pend_q.push_back(p);
        end
      end
    end
    chk("m_stall", stall, e_st);
    chk("m_mem_read", mem_read, e_rd);
    chk("m_mem_write", mem_write, e_wr);
    chk("m_mem_addr", mem_addr, e_addr);
    chk("m_mem_wdata", mem_wdata, e_wd);
    chk("m_load_data", load_data, e_ld);
    chk("m_fault_now", fault_now, e_fn);
    chk("m_fault_valid", fault_valid, efv);
    chk("m_fault_addr", fault_addr, efa);
    if (rst_n) begin
      if (fault_clear) begin efv = 0; efa = 0; end
      else if (e_fn && !efv) begin efv = 1; efa = req_addr; end
    end
  end

  task automatic drive(bit v, bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    req_valid = v; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    fault_clear = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h01010101 * i;
    ram[4] = 32'h11223344;
    ram[8] = 32'h80FF7F01;
    ram[13] = 32'hCAFEF00D;
    for (int i = 0; i < 64; i++) ref_mem[i] = ram[i];
    #2 rst_n = 0;
    drive(1, 0, F3_W, 32'h10, 0);
    #3 chk("rst_mem_read", mem_read, 0); chk("rst_load_data", load_data, 0);
    drive(1, 1, F3_W, 32'h10, 32'h5);
    #3 chk("rst_mem_write", mem_write, 0);
    drive(0, 0, F3_W, 0, 0);
    rst_n = 1;
    drive(1, 1, F3_B, 32'h13, 32'hAA);
    #3 chk("sb_c0_stall", stall, 1); chk("sb_c0_read", mem_read, 1); chk("sb_c0_addr", mem_addr, 32'h10);
    drive(1, 1, F3_B, 32'h13, 32'hAA);
    #3 chk("sb_c1_write", mem_write, 1); chk("sb_c1_wdata", mem_wdata, 32'hAA223344); chk("sb_c1_stall", stall, 0);
    drive(1, 1, F3_W, 32'h10, 32'hDEADBEEF);
    #3 chk("sw_write", mem_write, 1); chk("sw_addr", mem_addr, 32'h10); chk("sw_stall", stall, 0);
    drive(1, 0, F3_W, 32'h10, 0);
    #3 chk("lw_10", load_data, 32'hDEADBEEF);
    drive(1, 0, F3_B, 32'h22, 0);
    #3 chk("lb_22", load_data, 32'hFFFFFFFF);
    drive(1, 0, F3_BU, 32'h23, 0);
    #3 chk("lbu_23", load_data, 32'h00000080);
    drive(1, 0, F3_H, 32'h22, 0);
    #3 chk("lh_22", load_data, 32'hFFFF80FF);
    drive(1, 0, F3_HU, 32'h20, 0);
    #3 chk("lhu_20", load_data, 32'h00007F01);
    drive(1, 1, F3_H, 32'h22, 32'hCDEF1234);
    drive(1, 1, F3_H, 32'h22, 32'hCDEF1234);
    #3 chk("sh_c1_wdata", mem_wdata, 32'h12347F01);
    drive(1, 0, F3_W, 32'h20, 0);
    #3 chk("lw_20_after_sh", load_data, 32'h12347F01);
    drive(1, 0, F3_W, 32'hFC, 0);
    drive(1, 0, F3_W, 32'h06, 0);
    #3 chk("lw_06_fault", fault_now, 1); chk("lw_06_read", mem_read, 0);
    drive(1, 1, F3_H, 32'h101, 32'h77);
    #3 chk("fv_set", fault_valid, 1); chk("fa_06", fault_addr, 32'h06); chk("sh_101_stall", stall, 0);
    drive(0, 0, F3_W, 0, 0);
    #3 chk("fa_kept", fault_addr, 32'h06);
    fault_clear = 1;
    drive(1, 0, F3_HU, 32'h23, 0);
    #3 chk("clr_fv", fault_valid, 0); chk("lhu_23_fault", fault_now, 1);
    drive(1, 1, F3_BU, 32'h20, 32'h1);
    #3 chk("sbu_illegal", fault_now, 1); chk("sbu_write", mem_write, 0);
    drive(1, 0, F3_W, 32'h100, 0);
    fault_clear = 1;
    #3 chk("lw_100_fault", fault_now, 1); chk("lw_100_read", mem_read, 0);
    drive(1, 0, F3_W, 32'h100, 0);
    #3 chk("clr_priority", fault_valid, 0);
    drive(0, 0, F3_W, 0, 0);
    #3 chk("fa_100", fault_addr, 32'h100);
    drive(1, 1, F3_B, 32'h35, 32'h5A);
    drive(1, 1, F3_B, 32'h35, 32'h5A);
    rst_n = 0;
    #3 chk("rmw_abort_write", mem_write, 0);
    drive(0, 0, F3_W, 0, 0);
    rst_n = 1;
    #3 chk("abort_ram", ram[13], 32'hCAFEF00D); chk("post_rst_fv", fault_valid, 0); chk("post_rst_stall", stall, 0);
    drive(1, 0, F3_W, 32'h34, 0);
    #3 chk("lw_34", load_data, 32'hCAFEF00D);
    drive(0, 0, F3_W, 0, 0);
    repeat (2) @(posedge clk);
    #1 $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-organised data memory.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-wide memory accesses.
- Sign- or zero-extends load results.
- Implements sub-word stores as a two-cycle read-modify-write, stalling the core for one cycle.
- Detects misaligned and out-of-range accesses and latches the first fault for the trap logic.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in data memory; valid byte addresses are 0 .. 4*MEM_WORDS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory instruction present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address from the ALU.
- req_wdata  in  32  store data (rs2).
- stall  out  1  core must hold PC and request stable.
- load_data  out  32  extended load result, for writeback.
- fault_now  out  1  current request is misaligned or out of range, or has an illegal funct3.
- fault_valid  out  1  sticky fault flag.
- fault_addr  out  32  address of the first faulting request.
- fault_clear  in  1  clears fault_valid and fault_addr.
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_addr  out  32  word-aligned address: {addr[31:2], 2'b00}.
- mem_wdata  out  32  to data memory.
- mem_rdata  in  32  combinational read data from data memory.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, fault_valid=0, fault_addr=0, merge register=0.
  - All outputs are 0 while in reset.
  - Reset during RMW_WRITE aborts the store; no mem_write is issued.
- FSM states: IDLE, RMW_WRITE.
- Fault rules (combinational):
  - fault_now = req_valid & (W with addr[1:0]!=0, or H/HU/SH with addr[0]!=0, or addr >= 4*MEM_WORDS, or funct3 not legal for the direction).
  - A faulting request never asserts mem_read or mem_write, and never stalls.
  - On the clock edge with fault_now & !fault_valid: fault_valid<=1, fault_addr<=req_addr.
  - fault_clear has priority over capture.
- Loads (IDLE only):
  - mem_read=1 in the same cycle; zero latency.
  - load_data selects the byte or halfword by addr[1:0] or addr[1], then extends it: B/H sign-extend, BU/HU zero-extend, W passes through.
  - load_data=0 when there is no valid load.
- SW: in IDLE, mem_write=1 and mem_wdata=req_wdata in the same cycle; no stall.
- SB/SH:
  - IDLE cycle: mem_read=1, stall=1. Merge the store byte/halfword into mem_rdata at the lane given by addr. Register the merged word and the word address. Go to RMW_WRITE.
  - RMW_WRITE cycle: mem_write=1, mem_addr and mem_wdata taken from the registers, stall=0. The request inputs are ignored. Go to IDLE.
  - Total latency is 2 cycles.
- req_valid=0 in IDLE: no memory strobes, stall=0.
- mem_read and mem_write are never both high.

Decomposition:
- Shared package rv_mem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: IDLE, RMW_WRITE.
- One natural sub-module, lsu_lane_align. It is combinational and provides:
  - load extraction and extension.
  - store merge of byte/halfword into a word.

Test Plan:
- Reset: rst_n low mid-SB (in RMW_WRITE) -> no mem_write; after release state=IDLE, fault_valid=0.
- SW addr 0x10, data 0xDEADBEEF -> same cycle mem_write=1, mem_addr=0x10, no stall. Then LW 0x10 -> load_data=0xDEADBEEF.
- SB 0x13, data 0x000000AA, over a word of 0x11223344 -> cycle0 stall=1, mem_read=1; cycle1 mem_write=1, mem_wdata=0xAA223344, stall=0.
- Byte loads from a word of 0x80FF7F01 at 0x20:
  - LB 0x22 -> 0xFFFFFFFF.
  - LBU 0x23 -> 0x00000080.
  - LH 0x22 -> 0xFFFF80FF.
  - LHU 0x20 -> 0x00007F01.
- LW 0x06 -> fault_now=1, no strobes, fault_addr=0x06. A following SH 0x101 does not overwrite fault_addr. fault_clear -> fault_valid=0.
- LW 0x100 with MEM_WORDS=64 -> out-of-range fault, mem_read=0.
